// File: rtl/key_matrix_emu_if.sv
// Request/keypad bundle between a keypad-scanner-side driver and the matrix emulator.
// key_c is the scanner's column drive and key_r the emulated row response, both active-low.
interface key_matrix_emu_if;
  logic [3:0] key_c;
  logic       req_valid;
  logic [3:0] req_code;
  logic       req_ready;
  logic [3:0] key_r;
  logic       busy;
  logic       done;

  modport master (
    output key_c, req_valid, req_code,
    input  req_ready, key_r, busy, done
  );

  modport slave (
    input  key_c, req_valid, req_code,
    output req_ready, key_r, busy, done
  );
endinterface

// File: rtl/key_matrix_emu.sv
// 4x4 keypad emulator: presses one key for HOLD_CYCLES, then forces release for GAP_CYCLES.
// Row lines respond combinationally to the scanner's column drive.
module key_matrix_emu #(
  parameter int HOLD_CYCLES = 16,
  parameter int GAP_CYCLES  = 8
) (
  input logic             Clk,
  input logic             Rst_n,
  key_matrix_emu_if.slave kif
);

  localparam int MAX_CYC = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC) + 1;
  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRESS = 2'd1,
    GAP   = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       col_q, col_d;
  logic [1:0]       row_q, row_d;
  logic             done_q, done_d;
  logic [3:0]       row_drive;

  // Keymap lookup: returns {column index, row index}.
  function automatic logic [3:0] decode_key(input logic [3:0] code);
    logic [3:0] cr;
    cr = 4'h0;
    case (code)
      4'h1: cr = {2'd0, 2'd0};
      4'h4: cr = {2'd0, 2'd1};
      4'h7: cr = {2'd0, 2'd2};
      4'hA: cr = {2'd0, 2'd3};
      4'h2: cr = {2'd1, 2'd0};
      4'h5: cr = {2'd1, 2'd1};
      4'h8: cr = {2'd1, 2'd2};
      4'hB: cr = {2'd1, 2'd3};
      4'h3: cr = {2'd2, 2'd0};
      4'h6: cr = {2'd2, 2'd1};
      4'h9: cr = {2'd2, 2'd2};
      4'hC: cr = {2'd2, 2'd3};
      4'hF: cr = {2'd3, 2'd0};
      4'h0: cr = {2'd3, 2'd1};
      4'hE: cr = {2'd3, 2'd2};
      4'hD: cr = {2'd3, 2'd3};
      default: cr = 4'h0;
    endcase
    return cr;
  endfunction

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      col_q   <= 2'd0;
      row_q   <= 2'd0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      col_q   <= col_d;
      row_q   <= row_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    col_d   = col_q;
    row_d   = row_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (kif.req_valid) begin
          state_d        = PRESS;
          cnt_d          = HOLD_LOAD;
          {col_d, row_d} = decode_key(kif.req_code);
        end
      end
      PRESS: begin
        if (cnt_q == '0) begin
          state_d = GAP;
          cnt_d   = GAP_LOAD;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      GAP: begin
        // done is registered so it lands in the first IDLE cycle.
        if (cnt_q == '0) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Zero-latency row response so the scanner sees rows matching its current column.
  always_comb begin
    row_drive = 4'hF;
    if (state_q == PRESS && !kif.key_c[col_q]) begin
      row_drive[row_q] = 1'b0;
    end
  end

  assign kif.key_r     = row_drive;
  assign kif.req_ready = (state_q == IDLE);
  assign kif.busy      = (state_q != IDLE);
  assign kif.done      = done_q;

endmodule

// File: tb/tb_key_matrix_emu.sv
// Self-checking bench for key_matrix_emu: randomized column drive against a keypad-layout model.
// A second instance runs with the minimum hold/gap lengths.
module tb_key_matrix_emu;

  localparam int H = 16;
  localparam int G = 8;

  logic Clk = 1'b0;
  logic Rst_n = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  // Physical keypad layout, indexed [row][column].
  logic [3:0] layout [4][4] = '{
    '{4'h1, 4'h2, 4'h3, 4'hF},
    '{4'h4, 4'h5, 4'h6, 4'h0},
    '{4'h7, 4'h8, 4'h9, 4'hE},
    '{4'hA, 4'hB, 4'hC, 4'hD}
  };

  key_matrix_emu_if ifa();
  key_matrix_emu_if ifb();

  key_matrix_emu #(.HOLD_CYCLES(H), .GAP_CYCLES(G)) dut_a (
    .Clk(Clk), .Rst_n(Rst_n), .kif(ifa)
  );
  key_matrix_emu #(.HOLD_CYCLES(1), .GAP_CYCLES(1)) dut_b (
    .Clk(Clk), .Rst_n(Rst_n), .kif(ifb)
  );

  always #5 Clk = ~Clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int col_of(input logic [3:0] code);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (layout[r][c] == code) return c;
    return 0;
  endfunction

  function automatic int row_of(input logic [3:0] code);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (layout[r][c] == code) return r;
    return 0;
  endfunction

  // Expected rows: a pressed key connects its column to its row.
  function automatic logic [3:0] exp_kr(input logic pressed, input logic [3:0] code,
                                        input logic [3:0] kc);
    logic [3:0] v;
    v = 4'hF;
    if (pressed && kc[col_of(code)] == 1'b0) v[row_of(code)] = 1'b0;
    return v;
  endfunction

  function automatic logic [3:0] rand_kc();
    int p;
    logic [3:0] v;
    p = $urandom_range(0, 9);
    if (p < 7) v = ~(4'b0001 << $urandom_range(0, 3));
    else if (p < 8) v = 4'hF;
    else v = 4'($urandom_range(0, 15));
    return v;
  endfunction

  function automatic logic [3:0] col_low(input logic [3:0] code);
    logic [3:0] v;
    v = 4'hF;
    v[col_of(code)] = 1'b0;
    return v;
  endfunction

  task automatic accept_a(input logic [3:0] code);
    int w;
    w = 0;
    while (ifa.req_ready !== 1'b1 && w < 100) begin
      @(posedge Clk); #1;
      w++;
    end
    n_checks++;
    if (w >= 100) begin
      n_fail++;
      $display("FAIL accept_wait: req_ready got %b after %0d cycles, required 1", ifa.req_ready, w);
    end
    ifa.req_valid = 1'b1;
    ifa.req_code  = code;
    @(posedge Clk); #1;
    ifa.req_valid = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    n_checks++; if (ifa.key_r !== 4'hF) begin n_fail++; $display("FAIL reset_key_r: got %b required 1111", ifa.key_r); end
    n_checks++; if (ifa.req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b required 1", ifa.req_ready); end
    n_checks++; if (ifa.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b required 0", ifa.busy); end
    n_checks++; if (ifa.done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b required 0", ifa.done); end
    repeat (3) @(negedge Clk);
    Rst_n = 1'b1;
    @(posedge Clk); #1;
    ifa.key_c = 4'b1110; #1;
    n_checks++; if (ifa.key_r !== 4'hF) begin n_fail++; $display("FAIL idle_key_r: got %b required 1111", ifa.key_r); end
    n_checks++; if (ifa.busy !== 1'b0 || ifa.req_ready !== 1'b1) begin
      n_fail++; $display("FAIL idle_flags: busy %b ready %b required 0 1", ifa.busy, ifa.req_ready);
    end
  endtask

  task automatic test_single();
    logic [3:0] kc, er;
    accept_a(4'h9);
    for (int n = 0; n <= H + G; n++) begin
      kc = ~(4'b0001 << (n % 4));
      ifa.key_c = kc; #1;
      er = exp_kr(n < H, 4'h9, kc);
      n_checks++; if (ifa.key_r !== er) begin n_fail++; $display("FAIL single_key_r n=%0d key_c=%b: got %b required %b", n, kc, ifa.key_r, er); end
      n_checks++; if (ifa.busy !== (n < H + G)) begin n_fail++; $display("FAIL single_busy n=%0d: got %b", n, ifa.busy); end
      n_checks++; if (ifa.done !== (n == H + G)) begin n_fail++; $display("FAIL single_done n=%0d: got %b", n, ifa.done); end
      @(posedge Clk); #1;
    end
    n_checks++; if (ifa.done !== 1'b0) begin n_fail++; $display("FAIL single_done_width: got %b required 0", ifa.done); end
  endtask

  task automatic test_keymap();
    logic [3:0] kc, er;
    int dones;
    dones = 0;
    accept_a(4'h0);
    for (int code = 0; code < 16; code++) begin
      for (int n = 0; n <= H + G; n++) begin
        kc = (n == 1) ? col_low(4'(code)) : rand_kc();
        ifa.key_c = kc;
        if (n == H + G && code < 15) begin
          ifa.req_valid = 1'b1;
          ifa.req_code  = 4'(code + 1);
        end
        #1;
        er = exp_kr(n < H, 4'(code), kc);
        n_checks++; if (ifa.key_r !== er) begin n_fail++; $display("FAIL keymap_key_r code=%h n=%0d key_c=%b: got %b required %b", code, n, kc, ifa.key_r, er); end
        n_checks++; if (ifa.done !== (n == H + G)) begin n_fail++; $display("FAIL keymap_done code=%h n=%0d: got %b", code, n, ifa.done); end
        if (ifa.done === 1'b1) dones++;
        @(posedge Clk); #1;
        ifa.req_valid = 1'b0;
      end
    end
    n_checks++; if (dones != 16) begin n_fail++; $display("FAIL keymap_done_count: got %0d required 16", dones); end
  endtask

  task automatic test_busy();
    logic [3:0] c0, c1, kc, er;
    c0 = 4'($urandom_range(0, 15));
    c1 = 4'($urandom_range(0, 15));
    if (col_of(c1) == col_of(c0) && row_of(c1) == row_of(c0)) c1 = c0 ^ 4'h1;
    accept_a(c0);
    for (int n = 0; n <= H + G; n++) begin
      ifa.req_valid = 1'b1;
      ifa.req_code  = (n == H + G) ? c1 : 4'($urandom_range(0, 15));
      kc = (n % 2 == 1) ? col_low(c0) : rand_kc();
      ifa.key_c = kc; #1;
      er = exp_kr(n < H, c0, kc);
      n_checks++; if (ifa.key_r !== er) begin n_fail++; $display("FAIL busy_key_r n=%0d key_c=%b: got %b required %b", n, kc, ifa.key_r, er); end
      n_checks++; if (ifa.req_ready !== (n == H + G)) begin n_fail++; $display("FAIL busy_ready n=%0d: got %b", n, ifa.req_ready); end
      @(posedge Clk); #1;
    end
    for (int n = 0; n <= H + G; n++) begin
      ifa.req_valid = (n < H);
      ifa.req_code  = 4'($urandom_range(0, 15));
      kc = (n < H) ? col_low(c1) : rand_kc();
      ifa.key_c = kc; #1;
      er = exp_kr(n < H, c1, kc);
      n_checks++; if (ifa.key_r !== er) begin n_fail++; $display("FAIL busy_next_key_r n=%0d: got %b required %b", n, ifa.key_r, er); end
      n_checks++; if (ifa.done !== (n == H + G)) begin n_fail++; $display("FAIL busy_next_done n=%0d: got %b", n, ifa.done); end
      @(posedge Clk); #1;
    end
    ifa.req_valid = 1'b0;
  endtask

  // Behavioural column scanner: rotates one low column per cycle and stops on a hit.
  task automatic test_loopback();
    logic [3:0] kc, er, key_out;
    int n, found, hit_n;
    found = 0; hit_n = 0; n = 0; kc = 4'hF;
    accept_a(4'h5);
    while (!found && n < 8) begin
      kc = ~(4'b0001 << (n % 4));
      ifa.key_c = kc; #1;
      if (ifa.key_r !== 4'hF) begin
        found = 1;
        hit_n = n;
        key_out = 4'hF;
        for (int r = 0; r < 4; r++) if (ifa.key_r[r] == 1'b0) key_out = layout[r][n % 4];
        n_checks++; if (key_out !== 4'h5 || kc !== 4'b1101) begin n_fail++; $display("FAIL loopback_key_out: got %h on key_c %b required 5 on 1101", key_out, kc); end
      end
      @(posedge Clk); #1;
      n++;
    end
    n_checks++; if (!found || hit_n > 3) begin n_fail++; $display("FAIL loopback_scan_time: found %0d at cycle %0d required within 4", found, hit_n); end
    for (int m = n; m <= H + G; m++) begin
      if (m >= H) kc = ~(4'b0001 << (m % 4));
      ifa.key_c = kc; #1;
      er = exp_kr(m < H, 4'h5, kc);
      n_checks++; if (ifa.key_r !== er) begin n_fail++; $display("FAIL loopback_key_r m=%0d key_c=%b: got %b required %b", m, kc, ifa.key_r, er); end
      @(posedge Clk); #1;
    end
  endtask

  task automatic test_min();
    logic [3:0] code, kc, er;
    int w;
    code = 4'($urandom_range(0, 15));
    w = 0;
    while (ifb.req_ready !== 1'b1 && w < 20) begin @(posedge Clk); #1; w++; end
    n_checks++; if (w >= 20) begin n_fail++; $display("FAIL min_accept_wait: ready got %b required 1", ifb.req_ready); end
    ifb.req_valid = 1'b1;
    ifb.req_code  = code;
    @(posedge Clk); #1;
    ifb.req_valid = 1'b0;
    kc = col_low(code);
    for (int n = 0; n <= 2; n++) begin
      ifb.key_c = kc; #1;
      er = exp_kr(n < 1, code, kc);
      n_checks++; if (ifb.key_r !== er) begin n_fail++; $display("FAIL min_key_r n=%0d: got %b required %b", n, ifb.key_r, er); end
      n_checks++; if (ifb.busy !== (n < 2)) begin n_fail++; $display("FAIL min_busy n=%0d: got %b", n, ifb.busy); end
      n_checks++; if (ifb.done !== (n == 2)) begin n_fail++; $display("FAIL min_done n=%0d: got %b", n, ifb.done); end
      @(posedge Clk); #1;
    end
  endtask

  task automatic test_reset_mid();
    int seen_done;
    seen_done = 0;
    accept_a(4'h5);
    repeat (2) begin @(posedge Clk); #1; end
    ifa.key_c = 4'b1101; #1;
    n_checks++; if (ifa.key_r !== 4'b1101) begin n_fail++; $display("FAIL midreset_pre_key_r: got %b required 1101", ifa.key_r); end
    #2;
    Rst_n = 1'b0;
    #1;
    n_checks++; if (ifa.key_r !== 4'hF) begin n_fail++; $display("FAIL midreset_key_r: got %b required 1111", ifa.key_r); end
    n_checks++; if (ifa.busy !== 1'b0) begin n_fail++; $display("FAIL midreset_busy: got %b required 0", ifa.busy); end
    n_checks++; if (ifa.req_ready !== 1'b1) begin n_fail++; $display("FAIL midreset_ready: got %b required 1", ifa.req_ready); end
    repeat (3) @(negedge Clk);
    Rst_n = 1'b1;
    for (int n = 0; n < H + G + 4; n++) begin
      @(posedge Clk); #1;
      ifa.key_c = 4'b1101; #1;
      if (ifa.done !== 1'b0 || ifa.key_r !== 4'hF) seen_done = 1;
    end
    n_checks++; if (seen_done != 0) begin n_fail++; $display("FAIL midreset_no_done: activity seen after aborted request, required none"); end
  endtask

  initial begin
    ifa.key_c = 4'hF; ifa.req_valid = 1'b0; ifa.req_code = 4'h0;
    ifb.key_c = 4'hF; ifb.req_valid = 1'b0; ifb.req_code = 4'h0;
    test_reset();
    test_single();
    test_keymap();
    test_busy();
    test_loopback();
    test_min();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
